f1_random_delay: RTL

Pseudo-random hold-off timer for the F1 start-lights game. It sits directly downstream of the lights sequencer. It free-runs a 7-bit LFSR while the sequencer asserts `en_lfsr`. It captures a random delay when `start_delay` rises, counts it down in millisecond ticks, and returns a one-cycle `time_out` pulse that releases the sequencer from its all-lit state back to idle.

---
 rtl/f1_random_delay.sv | 121 ++++++++++++
 1 files changed

// File: rtl/f1_random_delay.sv
`default_nettype none
// ============================================================================
// Module      : f1_random_delay
// Description : Pseudo-random hold-off timer for the F1 start-lights game.
//               A free-running 7-bit Fibonacci LFSR (x^7+x^6+1) supplies a
//               random offset; a start edge captures
//               MIN_MS + (lfsr << SCALE_SH), which is counted down in 1 ms
//               ticks.  Expiry produces a one-cycle time_out pulse.
// Options     : F1_DELAY_ABORT_EN - when defined, abort cancels a running
//               countdown; otherwise abort is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module f1_random_delay #(
    parameter int unsigned MIN_MS   = 250,
    parameter int unsigned SCALE_SH = 4,
    parameter int unsigned CNT_W    = 14
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en_lfsr,
    input  logic             start_delay,
    input  logic             abort,
    output logic             time_out,
    output logic             busy,
    output logic [6:0]       lfsr_q,
    output logic [CNT_W-1:0] count_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] C_MIN = CNT_W'(MIN_MS);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] count_d;
    logic [6:0]       lfsr_d;
    logic             start_q;
    logic             start_evt;
    logic             abort_req;
    logic [CNT_W-1:0] load_val;

`ifdef F1_DELAY_ABORT_EN
    assign abort_req = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_req    = 1'b0;
`endif

    assign start_evt = start_delay & ~start_q;

    // Delay captured from the pre-step LFSR value, zero-extended to CNT_W.
    assign load_val = C_MIN + (CNT_W'(lfsr_q) << SCALE_SH);

    // Outputs decode directly from registered state only.
    assign busy     = (state_q == S_COUNT) || (state_q == S_DONE);
    assign time_out = (state_q == S_DONE);

    // LFSR next state: lock-up recovery from zero takes priority over enable.
    always_comb begin
        lfsr_d = lfsr_q;
        if (lfsr_q == 7'h00) begin
            lfsr_d = 7'h01;
        end else if (en_lfsr) begin
            lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // Countdown FSM next-state and counter logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (start_evt) begin
                    state_d = S_COUNT;
                    count_d = load_val;
                end
            end
            S_COUNT: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (tick) begin
                    count_d = count_q - C_ONE;
                    if (count_q == C_ONE) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, counter, LFSR and start-edge registers with synchronous reset.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            lfsr_q  <= 7'h01;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lfsr_q  <= lfsr_d;
            start_q <= start_delay;
        end
    end

endmodule
`default_nettype wire
